// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared definitions for the I2S transmit and capture paths.
//   DEF_DATA_W        default PCM sample width
//   DEF_SLOT_W        default SCK periods per channel slot
//   DEF_BCLK_HALF_DIV default system clocks per SCK half period
//   sample_pair_t     left/right sample pair at the default width
//   frame_bits()      SCK periods in one stereo frame for a given slot width
package i2s_pkg;

   localparam int DEF_DATA_W        = 24;
   localparam int DEF_SLOT_W        = 32;
   localparam int DEF_BCLK_HALF_DIV = 4;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] left;
      logic [DEF_DATA_W-1:0] right;
   } sample_pair_t;

   // One frame is a left slot followed by a right slot.
   function automatic int frame_bits(input int slot_w);
      return slot_w + slot_w;
   endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen
// Bus-master bit clock generator. Divides the system clock down to SCK and
// flags the system-clock cycle in which SCK is about to fall, so that the
// data side can update WS/SD on the same edge that SCK goes low.
// Ports:
//   clk_i      in   system clock
//   rst_i      in   asynchronous active-high reset
//   sck_o      out  bit clock (registered), 0 in reset
//   fall_stb_o out  high in the cycle whose closing edge drives SCK low
module i2s_sck_gen
   import i2s_pkg::*;
#(
   parameter int HALF_DIV = DEF_BCLK_HALF_DIV
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic sck_o,
   output logic fall_stb_o
);

   localparam int            DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [DW-1:0] TC = DW'(HALF_DIV - 1);

   logic [DW-1:0] r_div;
   logic          r_sck;
   logic          w_tc;

   assign w_tc = (r_div == TC);

   // Half-period counter; SCK toggles at terminal count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_div <= {DW{1'b0}};
         r_sck <= 1'b0;
      end else if (w_tc) begin
         r_div <= {DW{1'b0}};
         r_sck <= ~r_sck;
      end else begin
         r_div <= r_div + DW'(1);
      end
   end

   assign sck_o      = r_sck;
   // Terminal count while high means this edge is the falling one.
   assign fall_stb_o = w_tc & r_sck;

endmodule

// File: rtl/i2s_tx_24.sv
// i2s_tx_24
// Philips-format I2S transmitter, bus master. Accepts left/right PCM pairs on
// a valid/ready handshake into a one-deep holding register, moves the pair to
// the frame register at each frame boundary, and shifts it out MSB first with
// a one-SCK delay after each WS transition. An empty holding register at a
// boundary sends a silent frame and flags underrun.
// Ports:
//   clk_i           in   system clock (27 MHz)
//   rst_i           in   asynchronous active-high reset
//   left_sample_i   in   left PCM sample
//   right_sample_i  in   right PCM sample
//   sample_valid_i  in   sample pair present
//   sample_ready_o  out  holding register empty
//   sck_o           out  I2S bit clock
//   ws_o            out  word select, 0 = left, 1 = right
//   sd_o            out  serial data, changes on SCK fall
//   frame_stb_o     out  one-cycle pulse at each frame start
//   underrun_o      out  one-cycle pulse when a frame starts with no pair
module i2s_tx_24
   import i2s_pkg::*;
#(
   parameter int DATA_W        = DEF_DATA_W,
   parameter int SLOT_W        = DEF_SLOT_W,
   parameter int BCLK_HALF_DIV = DEF_BCLK_HALF_DIV
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] left_sample_i,
   input  logic [DATA_W-1:0] right_sample_i,
   input  logic              sample_valid_i,
   output logic              sample_ready_o,
   output logic              sck_o,
   output logic              ws_o,
   output logic              sd_o,
   output logic              frame_stb_o,
   output logic              underrun_o
);

   localparam int            NBITS   = frame_bits(SLOT_W);
   localparam int            BW      = $clog2(NBITS);
   localparam int            IW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] B_LAST  = BW'(NBITS - 1);
   localparam logic [BW-1:0] L_FIRST = BW'(1);
   localparam logic [BW-1:0] L_LAST  = BW'(DATA_W);
   localparam logic [BW-1:0] R_FIRST = BW'(SLOT_W + 1);
   localparam logic [BW-1:0] R_LAST  = BW'(SLOT_W + DATA_W);
   localparam logic [BW-1:0] WS_EDGE = BW'(SLOT_W);
   localparam logic [IW-1:0] MSB_IDX = IW'(DATA_W - 1);

   logic              w_fall_stb;
   logic              w_accept;
   logic              w_load;
   logic [BW-1:0]     w_b_next;
   logic [IW-1:0]     w_lidx;
   logic [IW-1:0]     w_ridx;
   logic              w_sd_next;

   logic [BW-1:0]     r_b;
   logic              r_ws;
   logic              r_sd;
   logic              r_empty;
   logic [DATA_W-1:0] r_hold_l;
   logic [DATA_W-1:0] r_hold_r;
   logic [DATA_W-1:0] r_frame_l;
   logic [DATA_W-1:0] r_frame_r;
   logic              r_frame_stb;
   logic              r_underrun;

   i2s_sck_gen #(
      .HALF_DIV (BCLK_HALF_DIV)
   ) u_sck_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .sck_o      (sck_o),
      .fall_stb_o (w_fall_stb)
   );

   assign w_accept = sample_valid_i & r_empty;
   // Frame boundary: the falling SCK on which the bit counter wraps.
   assign w_load   = w_fall_stb & (r_b == B_LAST);

   // Next bit position and the serial bit to present there.
   always_comb begin
      w_b_next  = {BW{1'b0}};
      w_sd_next = 1'b0;
      if (r_b == B_LAST) begin
         w_b_next = {BW{1'b0}};
      end else begin
         w_b_next = r_b + BW'(1);
      end
      // Only meaningful inside the matching data window.
      w_lidx = MSB_IDX - IW'(w_b_next - L_FIRST);
      w_ridx = MSB_IDX - IW'(w_b_next - R_FIRST);
      if ((w_b_next >= L_FIRST) && (w_b_next <= L_LAST)) begin
         w_sd_next = r_frame_l[w_lidx];
      end else if ((w_b_next >= R_FIRST) && (w_b_next <= R_LAST)) begin
         w_sd_next = r_frame_r[w_ridx];
      end else begin
         w_sd_next = 1'b0;
      end
   end

   // Bit counter, WS and SD all move together on the falling SCK.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_b  <= B_LAST;
         r_ws <= 1'b1;
         r_sd <= 1'b0;
      end else if (w_fall_stb) begin
         r_b  <= w_b_next;
         r_ws <= (w_b_next >= WS_EDGE);
         r_sd <= w_sd_next;
      end
   end

   // Holding register; an accept in the load cycle lands here for next frame.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_empty  <= 1'b1;
         r_hold_l <= {DATA_W{1'b0}};
         r_hold_r <= {DATA_W{1'b0}};
      end else if (w_accept) begin
         r_empty  <= 1'b0;
         r_hold_l <= left_sample_i;
         r_hold_r <= right_sample_i;
      end else if (w_load) begin
         r_empty  <= 1'b1;
      end
   end

   // Frame register load from the registered empty flag, no bypass.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_frame_l   <= {DATA_W{1'b0}};
         r_frame_r   <= {DATA_W{1'b0}};
         r_frame_stb <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_frame_stb <= w_load;
         r_underrun  <= w_load & r_empty;
         if (w_load) begin
            if (r_empty) begin
               r_frame_l <= {DATA_W{1'b0}};
               r_frame_r <= {DATA_W{1'b0}};
            end else begin
               r_frame_l <= r_hold_l;
               r_frame_r <= r_hold_r;
            end
         end
      end
   end

   assign sample_ready_o = r_empty;
   assign ws_o           = r_ws;
   assign sd_o           = r_sd;
   assign frame_stb_o    = r_frame_stb;
   assign underrun_o     = r_underrun;

endmodule
